execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Execute stage of the 5-stage pipelined MIPS core; sits directly downstream of decode.
//  - Holds the D->E pipeline register.
//  - Forwards operands from the M and W stages.
//  - Runs the ALU and selects the destination register.
//  - Owns an iterative 32x32 multiplier plus the HI/LO registers read by mfhi/mflo.
//  - Drives the E->M stage signals and a multiplier-busy flag for the hazard unit.
// PARAMETERS
//  WIDTH       32  datapath width
//  MULT_CYCLES 32  multiplier iterations (one partial product per cycle, radix-2)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low; clears all state
//  stallE       in   1   hold the D->E register
//  flushE       in   1   load a bubble into the D->E register
//  regwriteD, memwriteD, regdstD, multstartD, multsgnD  in 1  decode controls
//  wbsrcD       in   3   writeback source select, passed through
//  alucontrolD  in   3   ALU operation
//  alusrcD      in   2   B source: 00 reg, 01 signimm, 10 unsignimm
//  rd1D, rd2D   in   32  register operands
//  signimmD, unsignimmD, pcplus4D  in 32  immediates and PC+4
//  rsD, rtD, reD  in  5  register specifiers
//  forwardAE, forwardBE  in 2  operand source: 00 register, 01 resultW, 10 aluoutM
//  resultW, aluoutM  in  32  forwarding sources
//  regwriteE, memwriteE  out 1   controls to M
//  wbsrcE       out  3   writeback source to M
//  aluoutE, writedataE, pcplus4E  out 32  results to M
//  writeregE    out  5   destination register
//  rsE, rtE     out  5   specifiers to the hazard unit
//  hiE, loE     out  32  HI/LO register contents
//  multbusyE    out  1   multiply in progress
// BEHAVIOUR
//  - Reset: D->E register, HI, LO and the multiplier state go to 0, so every output is 0.
//  - D->E register, priority order: flushE, then stallE, then load.
//    - flushE=1: synchronous bubble; all fields 0, so regwrite, memwrite and multstart are 0.
//    - stallE=1 (flushE=0): hold all fields.
//    - Otherwise: capture the D inputs.
//  - Operand A = mux(forwardAE). Operand B forwarded = mux(forwardBE).
//    - Code 11 behaves as 00.
//    - writedataE = forwarded B.
//  - ALU B input = forwarded B, signimm or unsignimm per alusrcE; alusrcE=11 selects the register.
//  - ALU is combinational, result 32 bits; overflow is ignored, no traps.
//    - 000 and; 001 or; 010 add; 011 xor; 100 xnor (~(a^b)); 101 sub.
//    - 110 slt: signed compare, result {31'b0, a<b}.
//    - 111 lui: {b[15:0], 16'b0}.
//  - writeregE = regdstE ? reE : rtE. jal uses wbsrcE downstream; no special case here.
//  - Multiplier FSM states: IDLE and RUN.
//    - IDLE->RUN: multstartE=1 in IDLE. Latch the operands.
//      - Signed (multsgnE=1): latch magnitudes and record sign = a[31]^b[31].
//    - RUN: one shift-add per cycle over a 64-bit accumulator.
//    - RUN->IDLE: after MULT_CYCLES cycles, write {HI,LO} = product (two's complement if sign set).
//    - multbusyE=1 throughout RUN, i.e. MULT_CYCLES cycles starting the cycle after the start.
//    - HI/LO take the new value on the final RUN edge and are visible the next cycle.
//  - Boundary cases:
//    - multstartE while busy is ignored, with no effect on the running operation; the hazard unit must stall.
//    - flushE or stallE do not affect a running multiply.
//    - stallE holds multstartE; a start is accepted only in IDLE, so a held start retriggers once IDLE is reached.
//    - Signed -2^31 * -2^31 = 2^62, correct via 33-bit magnitudes.
//    - Reset during RUN aborts the operation and clears HI/LO.
//    - 0 operands produce 0 after the full latency; there is no early-out.
// STRUCTURE
//  - Shared package, also used by decode: ALU op codes, alusrc codes, forward-select codes, wbsrc codes.
//  - Sub-module mult_iter (ports: clk, reset, start, sgn, a, b, busy, hi, lo).
//  - ALU, forwarding muxes and the D->E register stay inline.
// TESTING
//  1. Reset low mid-stream -> all outputs 0, multbusyE=0 and hiE=loE=0 while low and after release.
//  2. add rd1=5, rd2=7 -> aluoutE=12. sub -> 0xFFFFFFFE. slt -1,1 -> 1. lui imm 0x1234 -> 0x12340000.
//  3. forwardAE=10, aluoutM=0x100, forwardBE=01, resultW=3, add -> 0x103 and writedataE=3.
//  4. mult 0xFFFFFFFF x 2 (sgn) -> busy 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//     multu on the same operands -> HI=1, LO=0xFFFFFFFE.
//  5. Second multstart at busy cycle 5 -> ignored; the first product is unchanged.
//     flushE during RUN -> product still written.
//  6. stallE=1 for 3 cycles with new D inputs -> E outputs held.
//     flushE=stallE=1 -> bubble: regwriteE=memwriteE=0.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared encodings for decode and execute stages
package execute_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_XNOR = 3'b100,
        ALU_SUB  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_LUI  = 3'b111
    } alu_op_t;

    // Code 11 is unused by decode and falls back to the register operand.
    typedef enum logic [1:0] {
        SRCB_REG       = 2'b00,
        SRCB_SIGNIMM   = 2'b01,
        SRCB_UNSIGNIMM = 2'b10,
        SRCB_RSVD      = 2'b11
    } alusrc_t;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_RESULTW = 2'b01,
        FWD_ALUOUTM = 2'b10,
        FWD_RSVD    = 2'b11
    } fwd_sel_t;

    typedef enum logic [2:0] {
        WB_ALU   = 3'b000,
        WB_MEM   = 3'b001,
        WB_PCP4  = 3'b010,
        WB_HI    = 3'b011,
        WB_LO    = 3'b100
    } wbsrc_t;

    typedef enum logic {
        MULT_IDLE = 1'b0,
        MULT_RUN  = 1'b1
    } mult_state_t;

endpackage

// File: rtl/execute_stage_mult_iter.sv
// rtl/execute_stage_mult_iter.sv - radix-2 iterative multiplier owning HI/LO
module mult_iter
    import execute_stage_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    mult_state_t          state;
    mult_state_t          state_next;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH:0]       mplier;
    logic [WIDTH:0]       mag_a;
    logic [WIDTH:0]       mag_b;
    logic                 neg;
    logic                 last;

    // 33-bit magnitudes keep -2^31 representable as a positive value.
    always_comb begin
        mag_a    = (sgn && a[WIDTH-1]) ? -{1'b1, a} : {1'b0, a};
        mag_b    = (sgn && b[WIDTH-1]) ? -{1'b1, b} : {1'b0, b};
        acc_next = mplier[0] ? (acc + mcand) : acc;
        product  = neg ? -acc_next : acc_next;
        last     = (state == MULT_RUN) && (cnt == CW'(MULT_CYCLES - 1));
        busy     = (state == MULT_RUN);
    end

    always_comb begin
        state_next = state;
        case (state)
            MULT_IDLE: if (start) state_next = MULT_RUN;
            MULT_RUN:  if (last)  state_next = MULT_IDLE;
            default:   state_next = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MULT_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == MULT_IDLE) begin
            if (start) begin
                acc    <= '0;
                mcand  <= {{(WIDTH-1){1'b0}}, mag_a};
                mplier <= mag_b;
                cnt    <= '0;
                neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            end
        end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) {hi, lo} <= product;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS execute stage: D->E register, forwarding, ALU, multiplier
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             regwriteD,
    input  logic             memwriteD,
    input  logic             regdstD,
    input  logic             multstartD,
    input  logic             multsgnD,
    input  logic [2:0]       wbsrcD,
    input  logic [2:0]       alucontrolD,
    input  logic [1:0]       alusrcD,
    input  logic [WIDTH-1:0] rd1D,
    input  logic [WIDTH-1:0] rd2D,
    input  logic [WIDTH-1:0] signimmD,
    input  logic [WIDTH-1:0] unsignimmD,
    input  logic [WIDTH-1:0] pcplus4D,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       reD,
    input  logic [1:0]       forwardAE,
    input  logic [1:0]       forwardBE,
    input  logic [WIDTH-1:0] resultW,
    input  logic [WIDTH-1:0] aluoutM,
    output logic             regwriteE,
    output logic             memwriteE,
    output logic [2:0]       wbsrcE,
    output logic [WIDTH-1:0] aluoutE,
    output logic [WIDTH-1:0] writedataE,
    output logic [WIDTH-1:0] pcplus4E,
    output logic [4:0]       writeregE,
    output logic [4:0]       rsE,
    output logic [4:0]       rtE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE,
    output logic             multbusyE
);

    logic             regdst_q;
    logic             multstart_q;
    logic             multsgn_q;
    alu_op_t          alucontrol_q;
    alusrc_t          alusrc_q;
    logic [WIDTH-1:0] rd1_q;
    logic [WIDTH-1:0] rd2_q;
    logic [WIDTH-1:0] signimm_q;
    logic [WIDTH-1:0] unsignimm_q;
    logic [4:0]       re_q;

    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb_fwd;
    logic [WIDTH-1:0] srcb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regwriteE    <= 1'b0;
            memwriteE    <= 1'b0;
            regdst_q     <= 1'b0;
            multstart_q  <= 1'b0;
            multsgn_q    <= 1'b0;
            wbsrcE       <= '0;
            alucontrol_q <= ALU_AND;
            alusrc_q     <= SRCB_REG;
            rd1_q        <= '0;
            rd2_q        <= '0;
            signimm_q    <= '0;
            unsignimm_q  <= '0;
            pcplus4E     <= '0;
            rsE          <= '0;
            rtE          <= '0;
            re_q         <= '0;
        end else if (flushE) begin
            regwriteE    <= 1'b0;
            memwriteE    <= 1'b0;
            regdst_q     <= 1'b0;
            multstart_q  <= 1'b0;
            multsgn_q    <= 1'b0;
            wbsrcE       <= '0;
            alucontrol_q <= ALU_AND;
            alusrc_q     <= SRCB_REG;
            rd1_q        <= '0;
            rd2_q        <= '0;
            signimm_q    <= '0;
            unsignimm_q  <= '0;
            pcplus4E     <= '0;
            rsE          <= '0;
            rtE          <= '0;
            re_q         <= '0;
        end else if (!stallE) begin
            regwriteE    <= regwriteD;
            memwriteE    <= memwriteD;
            regdst_q     <= regdstD;
            multstart_q  <= multstartD;
            multsgn_q    <= multsgnD;
            wbsrcE       <= wbsrcD;
            alucontrol_q <= alu_op_t'(alucontrolD);
            alusrc_q     <= alusrc_t'(alusrcD);
            rd1_q        <= rd1D;
            rd2_q        <= rd2D;
            signimm_q    <= signimmD;
            unsignimm_q  <= unsignimmD;
            pcplus4E     <= pcplus4D;
            rsE          <= rsD;
            rtE          <= rtD;
            re_q         <= reD;
        end
    end

    always_comb begin
        srca = rd1_q;
        case (fwd_sel_t'(forwardAE))
            FWD_RESULTW: srca = resultW;
            FWD_ALUOUTM: srca = aluoutM;
            default:     srca = rd1_q;
        endcase

        srcb_fwd = rd2_q;
        case (fwd_sel_t'(forwardBE))
            FWD_RESULTW: srcb_fwd = resultW;
            FWD_ALUOUTM: srcb_fwd = aluoutM;
            default:     srcb_fwd = rd2_q;
        endcase

        srcb = srcb_fwd;
        case (alusrc_q)
            SRCB_SIGNIMM:   srcb = signimm_q;
            SRCB_UNSIGNIMM: srcb = unsignimm_q;
            default:        srcb = srcb_fwd;
        endcase
    end

    always_comb begin
        aluoutE = '0;
        case (alucontrol_q)
            ALU_AND:  aluoutE = srca & srcb;
            ALU_OR:   aluoutE = srca | srcb;
            ALU_ADD:  aluoutE = srca + srcb;
            ALU_XOR:  aluoutE = srca ^ srcb;
            ALU_XNOR: aluoutE = ~(srca ^ srcb);
            ALU_SUB:  aluoutE = srca - srcb;
            ALU_SLT:  aluoutE = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            ALU_LUI:  aluoutE = {srcb[15:0], {(WIDTH-16){1'b0}}};
            default:  aluoutE = '0;
        endcase
    end

    assign writedataE = srcb_fwd;
    assign writeregE  = regdst_q ? re_q : rtE;

    // Multiplies read the forwarded register operands, never the immediates.
    mult_iter #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .start (multstart_q),
        .sgn   (multsgn_q),
        .a     (srca),
        .b     (srcb_fwd),
        .busy  (multbusyE),
        .hi    (hiE),
        .lo    (loE)
    );

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - randomized scoreboard bench for execute_stage
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallE, flushE;
    logic        regwriteD, memwriteD, regdstD, multstartD, multsgnD;
    logic [2:0]  wbsrcD, alucontrolD;
    logic [1:0]  alusrcD;
    logic [31:0] rd1D, rd2D, signimmD, unsignimmD, pcplus4D;
    logic [4:0]  rsD, rtD, reD;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] resultW, aluoutM;
    logic        regwriteE, memwriteE;
    logic [2:0]  wbsrcE;
    logic [31:0] aluoutE, writedataE, pcplus4E;
    logic [4:0]  writeregE, rsE, rtE;
    logic [31:0] hiE, loE;
    logic        multbusyE;

    execute_stage dut (
        .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
        .regwriteD(regwriteD), .memwriteD(memwriteD), .regdstD(regdstD),
        .multstartD(multstartD), .multsgnD(multsgnD), .wbsrcD(wbsrcD),
        .alucontrolD(alucontrolD), .alusrcD(alusrcD), .rd1D(rd1D), .rd2D(rd2D),
        .signimmD(signimmD), .unsignimmD(unsignimmD), .pcplus4D(pcplus4D),
        .rsD(rsD), .rtD(rtD), .reD(reD), .forwardAE(forwardAE), .forwardBE(forwardBE),
        .resultW(resultW), .aluoutM(aluoutM), .regwriteE(regwriteE), .memwriteE(memwriteE),
        .wbsrcE(wbsrcE), .aluoutE(aluoutE), .writedataE(writedataE), .pcplus4E(pcplus4E),
        .writeregE(writeregE), .rsE(rsE), .rtE(rtE), .hiE(hiE), .loE(loE),
        .multbusyE(multbusyE)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit regwrite, memwrite, regdst, multstart, multsgn;
        bit [2:0] wbsrc, aluctl;
        bit [1:0] alusrc;
        bit [31:0] rd1, rd2, simm, uimm, pc4;
        bit [4:0] rs, rt, re;
    } instr_t;

    typedef struct {
        bit regwrite, memwrite, busy, lit;
        bit [2:0] wbsrc;
        bit [31:0] alu, wd, pc4, hi, lo, lit_alu, lit_wd;
        bit [4:0] wreg, rs, rt;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     failures = 0;

    // Reference state: the instruction sitting in E, HI/LO and multiply cycles left.
    instr_t      m_e;
    int          m_rem;
    bit [31:0]   m_hi, m_lo;
    bit [63:0]   m_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t nop();
        instr_t d;
        d = '{default: 0};
        return d;
    endfunction

    function automatic bit [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t d;
        d.regwrite  = 1'($urandom);
        d.memwrite  = 1'($urandom);
        d.regdst    = 1'($urandom);
        d.multstart = ($urandom_range(0, 7) == 0);
        d.multsgn   = 1'($urandom);
        d.wbsrc     = 3'($urandom);
        d.aluctl    = 3'($urandom);
        d.alusrc    = 2'($urandom);
        d.rd1       = pick_val();
        d.rd2       = pick_val();
        d.simm      = pick_val();
        d.uimm      = pick_val();
        d.pc4       = $urandom;
        d.rs        = 5'($urandom);
        d.rt        = 5'($urandom);
        d.re        = 5'($urandom);
        return d;
    endfunction

    function automatic bit [31:0] pick(bit [1:0] sel, bit [31:0] r, bit [31:0] w, bit [31:0] m);
        if (sel == 2'b01) return w;
        if (sel == 2'b10) return m;
        return r;
    endfunction

    function automatic bit [31:0] alu_ref(bit [2:0] op, bit [31:0] a, bit [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd3: return a ^ b;
            3'd4: return ~(a ^ b);
            3'd5: return a - b;
            3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return {b[15:0], 16'h0000};
        endcase
    endfunction

    task automatic drive(input instr_t d, input bit stall, input bit flush);
        regwriteD = d.regwrite; memwriteD = d.memwrite; regdstD = d.regdst;
        multstartD = d.multstart; multsgnD = d.multsgn; wbsrcD = d.wbsrc;
        alucontrolD = d.aluctl; alusrcD = d.alusrc; rd1D = d.rd1; rd2D = d.rd2;
        signimmD = d.simm; unsignimmD = d.uimm; pcplus4D = d.pc4;
        rsD = d.rs; rtD = d.rt; reD = d.re;
        stallE = stall; flushE = flush;
    endtask

    task automatic step(input instr_t nd, input bit stall, input bit flush,
                        input bit [1:0] fa, input bit [1:0] fb,
                        input bit [31:0] resw, input bit [31:0] alum,
                        input bit lit, input bit [31:0] lit_alu, input bit [31:0] lit_wd);
        exp_t x;
        bit [31:0] a, bf, b;
        @(posedge clk); #1;
        reset = 1'b1;
        forwardAE = fa; forwardBE = fb; resultW = resw; aluoutM = alum;
        a  = pick(fa, m_e.rd1, resw, alum);
        bf = pick(fb, m_e.rd2, resw, alum);
        b  = (m_e.alusrc == 2'b01) ? m_e.simm : (m_e.alusrc == 2'b10) ? m_e.uimm : bf;
        x.regwrite = m_e.regwrite; x.memwrite = m_e.memwrite; x.wbsrc = m_e.wbsrc;
        x.alu = alu_ref(m_e.aluctl, a, b); x.wd = bf; x.pc4 = m_e.pc4;
        x.wreg = m_e.regdst ? m_e.re : m_e.rt; x.rs = m_e.rs; x.rt = m_e.rt;
        x.hi = m_hi; x.lo = m_lo; x.busy = (m_rem > 0);
        x.lit = lit; x.lit_alu = lit_alu; x.lit_wd = lit_wd;
        sb.push_back(x);
        drive(nd, stall, flush);
        if (m_rem == 0) begin
            if (m_e.multstart) begin
                m_rem  = 32;
                m_pend = m_e.multsgn ? 64'($signed({{32{a[31]}}, a}) * $signed({{32{bf[31]}}, bf}))
                                     : {32'h0, a} * {32'h0, bf};
            end
        end else begin
            m_rem--;
            if (m_rem == 0) {m_hi, m_lo} = m_pend;
        end
        if (flush)       m_e = nop();
        else if (!stall) m_e = nd;
    endtask

    task automatic go(input instr_t nd, input bit stall, input bit flush);
        step(nd, stall, flush, 2'($urandom), 2'($urandom), $urandom, $urandom, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic regs(input instr_t nd);
        step(nd, 1'b0, 1'b0, 2'b00, 2'b00, $urandom, $urandom, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic golit(input instr_t nd, input bit [1:0] fa, input bit [1:0] fb,
                         input bit [31:0] resw, input bit [31:0] alum,
                         input bit [31:0] lit_alu, input bit [31:0] lit_wd);
        step(nd, 1'b0, 1'b0, fa, fb, resw, alum, 1'b1, lit_alu, lit_wd);
    endtask

    task automatic reset_phase(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset = 1'b0;
            m_e = nop(); m_rem = 0; m_hi = '0; m_lo = '0;
            forwardAE = 2'b00; forwardBE = 2'b00; resultW = $urandom; aluoutM = $urandom;
            sb.push_back('{default: 0});
            drive(rand_instr(), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic mult_run(input bit sgn, input bit [31:0] a, input bit [31:0] b, input int tail);
        instr_t d;
        d = nop(); d.multstart = 1'b1; d.multsgn = sgn; d.rd1 = a; d.rd2 = b;
        go(d, 1'b0, 1'b0);
        regs(nop());
        repeat (tail) go(nop(), 1'b0, 1'b0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                chk("regwriteE", regwriteE, x.regwrite);
                chk("memwriteE", memwriteE, x.memwrite);
                chk("wbsrcE", wbsrcE, x.wbsrc);
                chk("aluoutE", aluoutE, x.alu);
                chk("writedataE", writedataE, x.wd);
                chk("pcplus4E", pcplus4E, x.pc4);
                chk("writeregE", writeregE, x.wreg);
                chk("rsE", rsE, x.rs);
                chk("rtE", rtE, x.rt);
                chk("hiE", hiE, x.hi);
                chk("loE", loE, x.lo);
                chk("multbusyE", multbusyE, x.busy);
                if (x.lit) begin
                    chk("lit_aluoutE", aluoutE, x.lit_alu);
                    chk("lit_writedataE", writedataE, x.lit_wd);
                end
            end
        end
    end

    initial begin
        instr_t d;
        reset = 1'b0;
        m_e = nop(); m_rem = 0; m_hi = '0; m_lo = '0; m_pend = '0;
        forwardAE = 2'b00; forwardBE = 2'b00; resultW = '0; aluoutM = '0;
        drive(nop(), 1'b0, 1'b0);
        reset_phase(2);

        d = nop(); d.aluctl = 3'b010; d.rd1 = 32'd5; d.rd2 = 32'd7;
        d.regwrite = 1'b1; d.regdst = 1'b1; d.rs = 5'd1; d.rt = 5'd2; d.re = 5'd3;
        go(d, 1'b0, 1'b0);
        d.aluctl = 3'b101;
        golit(d, 2'b00, 2'b00, 32'h0, 32'h0, 32'd12, 32'd7);
        d.aluctl = 3'b110; d.rd1 = 32'hFFFF_FFFF; d.rd2 = 32'd1;
        golit(d, 2'b00, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'd7);
        d = nop(); d.aluctl = 3'b111; d.alusrc = 2'b10; d.uimm = 32'h0000_1234;
        golit(d, 2'b00, 2'b00, 32'h0, 32'h0, 32'd1, 32'd1);
        d = rand_instr(); d.aluctl = 3'b010; d.alusrc = 2'b00; d.multstart = 1'b0;
        golit(d, 2'b00, 2'b00, 32'h0, 32'h0, 32'h1234_0000, 32'h0);
        golit(nop(), 2'b10, 2'b01, 32'd3, 32'h100, 32'h103, 32'd3);

        mult_run(1'b1, 32'hFFFF_FFFF, 32'd2, 34);
        mult_run(1'b0, 32'hFFFF_FFFF, 32'd2, 34);
        mult_run(1'b1, 32'h8000_0000, 32'h8000_0000, 34);
        mult_run(1'b0, 32'h0, 32'h0, 34);

        // Second start at busy cycle 5 and a flush mid-run must not disturb the first product.
        mult_run(1'b1, 32'h1234_5678, 32'hFEDC_BA98, 3);
        d = nop(); d.multstart = 1'b1; d.rd1 = 32'd9; d.rd2 = 32'd9;
        go(d, 1'b0, 1'b0);
        repeat (6) go(nop(), 1'b0, 1'b0);
        go(nop(), 1'b0, 1'b1);
        repeat (30) go(nop(), 1'b0, 1'b0);

        d = rand_instr(); d.multstart = 1'b0;
        go(d, 1'b0, 1'b0);
        repeat (3) go(rand_instr(), 1'b1, 1'b0);
        go(rand_instr(), 1'b1, 1'b1);
        go(nop(), 1'b0, 1'b0);

        // A held start retriggers once the multiplier returns to idle.
        d = nop(); d.multstart = 1'b1; d.multsgn = 1'b1; d.rd1 = 32'hFFFF_FFF0; d.rd2 = 32'd77;
        go(d, 1'b0, 1'b0);
        repeat (40) go(rand_instr(), 1'b1, 1'b0);
        repeat (34) go(nop(), 1'b0, 1'b0);

        mult_run(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 10);
        reset_phase(2);
        repeat (3) go(nop(), 1'b0, 1'b0);

        repeat (600) go(rand_instr(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        repeat (40) go(nop(), 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
